// File: rtl/bios_rom_copier.sv
// Boot-time copier: streams ROM_SIZE bytes from the BIOS ROM into memory at MEM_BASE,
// then hands the memory bus to the CPU as a combinational pass-through.
module bios_rom_copier #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int ROM_SIZE = 256,
    parameter int MEM_BASE = 0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] rom_addr_bus,
    input  logic [DATA_W-1:0] rom_read_bus,
    output logic [1:0]        mem_ctrl_bus,
    output logic [ADDR_W-1:0] mem_addr_bus,
    output logic [DATA_W-1:0] mem_write_bus,
    input  logic [DATA_W-1:0] mem_read_bus,
    input  logic [1:0]        cpu_ctrl_bus,
    input  logic [ADDR_W-1:0] cpu_addr_bus,
    input  logic [DATA_W-1:0] cpu_write_bus,
    output logic [DATA_W-1:0] cpu_read_bus,
    output logic              cpu_hold,
    output logic              load_done
);

    typedef enum logic [1:0] {
        COPY,
        DRAIN,
        RUN
    } state_t;

    localparam logic [1:0]        CMD_NOP   = 2'b00;
    localparam logic [1:0]        CMD_WRITE = 2'b10;
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(ROM_SIZE - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] wr_addr;

    // ROM data lags its address by one cycle, so the byte arriving now belongs to cnt-1.
    assign wr_addr = BASE + cnt_q[ADDR_W-1:0] - ONE;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= COPY;
            cnt_q      <= '0;
            wr_vld_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_vld_q   <= wr_vld_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_vld_d      = wr_vld_q;
        rom_addr_d    = rom_addr_q;
        rom_addr_bus  = rom_addr_q;
        mem_ctrl_bus  = CMD_NOP;
        mem_addr_bus  = '0;
        mem_write_bus = '0;
        cpu_read_bus  = '0;
        cpu_hold      = 1'b1;
        load_done     = 1'b0;
        case (state_q)
            COPY: begin
                rom_addr_bus = cnt_q[ADDR_W-1:0];
                rom_addr_d   = cnt_q[ADDR_W-1:0];
                cnt_d        = cnt_q + 1'b1;
                wr_vld_d     = 1'b1;
                if (wr_vld_q) begin
                    mem_ctrl_bus  = CMD_WRITE;
                    mem_addr_bus  = wr_addr;
                    mem_write_bus = rom_read_bus;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_ctrl_bus  = CMD_WRITE;
                mem_addr_bus  = wr_addr;
                mem_write_bus = rom_read_bus;
                state_d       = RUN;
            end
            RUN: begin
                mem_ctrl_bus  = cpu_ctrl_bus;
                mem_addr_bus  = cpu_addr_bus;
                mem_write_bus = cpu_write_bus;
                cpu_read_bus  = mem_read_bus;
                cpu_hold      = 1'b0;
                load_done     = 1'b1;
            end
            default: begin
                state_d = COPY;
            end
        endcase
    end

endmodule

// File: tb/tb_bios_rom_copier.sv
// Directed bench for bios_rom_copier: three instances (small ROM, wrapping base, full 256-byte ROM)
// with behavioural ROM and memory models around them.
module tb_bios_rom_copier;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cpu_ctrl;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wr;

    always #5 clk = ~clk;

    logic [7:0] rom_addr_a, rom_q_a, mem_addr_a, mem_wr_a, mem_rd_a, cpu_rd_a;
    logic [1:0] mem_ctrl_a;
    logic       hold_a, done_a;
    logic [7:0] rom_addr_b, rom_q_b, mem_addr_b, mem_wr_b, mem_rd_b, cpu_rd_b;
    logic [1:0] mem_ctrl_b;
    logic       hold_b, done_b;
    logic [7:0] rom_addr_c, rom_q_c, mem_addr_c, mem_wr_c, mem_rd_c, cpu_rd_c;
    logic [1:0] mem_ctrl_c;
    logic       hold_c, done_c;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] mem_c [256];

    int total = 0;
    int bad   = 0;
    int wcnt_c;
    logic [7:0] last_c;

    bios_rom_copier #(.ADDR_W(8), .DATA_W(8), .ROM_SIZE(4), .MEM_BASE(10)) u_a (
        .CLOCK(clk), .RESET(rst),
        .rom_addr_bus(rom_addr_a), .rom_read_bus(rom_q_a),
        .mem_ctrl_bus(mem_ctrl_a), .mem_addr_bus(mem_addr_a),
        .mem_write_bus(mem_wr_a), .mem_read_bus(mem_rd_a),
        .cpu_ctrl_bus(cpu_ctrl), .cpu_addr_bus(cpu_addr), .cpu_write_bus(cpu_wr),
        .cpu_read_bus(cpu_rd_a), .cpu_hold(hold_a), .load_done(done_a));

    bios_rom_copier #(.ADDR_W(8), .DATA_W(8), .ROM_SIZE(4), .MEM_BASE(8'hFE)) u_b (
        .CLOCK(clk), .RESET(rst),
        .rom_addr_bus(rom_addr_b), .rom_read_bus(rom_q_b),
        .mem_ctrl_bus(mem_ctrl_b), .mem_addr_bus(mem_addr_b),
        .mem_write_bus(mem_wr_b), .mem_read_bus(mem_rd_b),
        .cpu_ctrl_bus(cpu_ctrl), .cpu_addr_bus(cpu_addr), .cpu_write_bus(cpu_wr),
        .cpu_read_bus(cpu_rd_b), .cpu_hold(hold_b), .load_done(done_b));

    bios_rom_copier #(.ADDR_W(8), .DATA_W(8), .ROM_SIZE(256), .MEM_BASE(0)) u_c (
        .CLOCK(clk), .RESET(rst),
        .rom_addr_bus(rom_addr_c), .rom_read_bus(rom_q_c),
        .mem_ctrl_bus(mem_ctrl_c), .mem_addr_bus(mem_addr_c),
        .mem_write_bus(mem_wr_c), .mem_read_bus(mem_rd_c),
        .cpu_ctrl_bus(cpu_ctrl), .cpu_addr_bus(cpu_addr), .cpu_write_bus(cpu_wr),
        .cpu_read_bus(cpu_rd_c), .cpu_hold(hold_c), .load_done(done_c));

    // ROMs: a and b hold A0..A3, c holds addr^5A; one-cycle registered read.
    always @(posedge clk) begin
        rom_q_a <= 8'hA0 + rom_addr_a;
        rom_q_b <= 8'hA0 + rom_addr_b;
        rom_q_c <= rom_addr_c ^ 8'h5A;
    end

    always @(posedge clk) begin
        if (mem_ctrl_a == 2'b10) mem_a[mem_addr_a] <= mem_wr_a;
        if (mem_ctrl_b == 2'b10) mem_b[mem_addr_b] <= mem_wr_b;
        if (mem_ctrl_c == 2'b10) mem_c[mem_addr_c] <= mem_wr_c;
    end

    assign mem_rd_a = mem_a[mem_addr_a];
    assign mem_rd_b = mem_b[mem_addr_b];
    assign mem_rd_c = mem_c[mem_addr_c];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_c <= 0;
            last_c <= 8'h00;
        end else if (mem_ctrl_c == 2'b10 && !done_c) begin
            wcnt_c <= wcnt_c + 1;
            last_c <= mem_addr_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] e_ctrl  [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [7:0] e_addra [6] = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h05};
    logic [7:0] e_addrb [6] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h05};
    logic [7:0] e_data  [6] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h55};
    logic [7:0] e_rom   [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03};

    initial begin
        rst      = 1'b1;
        cpu_ctrl = 2'b10;
        cpu_addr = 8'h05;
        cpu_wr   = 8'h55;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl",  32'(mem_ctrl_a), 32'd0);
        chk("rst_addr",  32'(mem_addr_a), 32'd0);
        chk("rst_wdata", 32'(mem_wr_a),   32'd0);
        chk("rst_rom",   32'(rom_addr_a), 32'd0);
        chk("rst_hold",  32'(hold_a),     32'd1);
        chk("rst_done",  32'(done_a),     32'd0);
        chk("rst_cpurd", 32'(cpu_rd_a),   32'd0);

        // Abort partway through the copy.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ab_c0_ctrl", 32'(mem_ctrl_a), 32'd0);
        @(negedge clk); #1;
        chk("ab_c1_ctrl", 32'(mem_ctrl_a), 32'd2);
        chk("ab_c1_addr", 32'(mem_addr_a), 32'h0A);
        chk("ab_c1_data", 32'(mem_wr_a),   32'hA0);
        @(negedge clk); #1;
        chk("ab_c2_addr", 32'(mem_addr_a), 32'h0B);
        chk("ab_c2_rom",  32'(rom_addr_a), 32'd2);
        rst = 1'b1;
        #1;
        chk("ab_async_ctrl", 32'(mem_ctrl_a), 32'd0);
        chk("ab_async_addr", 32'(mem_addr_a), 32'd0);
        chk("ab_async_data", 32'(mem_wr_a),   32'd0);
        chk("ab_async_rom",  32'(rom_addr_a), 32'd0);
        chk("ab_async_hold", 32'(hold_a),     32'd1);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 258; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k <= 5) begin
                chk($sformatf("a_ctrl_%0d", k),  32'(mem_ctrl_a), 32'(e_ctrl[k]));
                chk($sformatf("a_addr_%0d", k),  32'(mem_addr_a), 32'(e_addra[k]));
                chk($sformatf("a_data_%0d", k),  32'(mem_wr_a),   32'(e_data[k]));
                chk($sformatf("a_rom_%0d", k),   32'(rom_addr_a), 32'(e_rom[k]));
                chk($sformatf("a_hold_%0d", k),  32'(hold_a),     (k < 5) ? 32'd1 : 32'd0);
                chk($sformatf("a_done_%0d", k),  32'(done_a),     (k == 5) ? 32'd1 : 32'd0);
                chk($sformatf("b_ctrl_%0d", k),  32'(mem_ctrl_b), 32'(e_ctrl[k]));
                chk($sformatf("b_addr_%0d", k),  32'(mem_addr_b), 32'(e_addrb[k]));
                if (k < 5) chk($sformatf("a_cpurd_%0d", k), 32'(cpu_rd_a), 32'd0);
            end
            if (k == 256) begin
                chk("c_done_256", 32'(done_c),     32'd0);
                chk("c_ctrl_256", 32'(mem_ctrl_c), 32'd2);
                chk("c_addr_256", 32'(mem_addr_c), 32'hFF);
                chk("c_data_256", 32'(mem_wr_c),   32'hA5);
            end
            if (k == 257) begin
                chk("c_done_257", 32'(done_c),     32'd1);
                chk("c_wcount",   32'(wcnt_c),     32'd256);
                chk("c_last",     32'(last_c),     32'hFF);
                chk("c_mem0",     32'(mem_c[0]),   32'h5A);
                chk("c_mem255",   32'(mem_c[255]), 32'hA5);
            end
        end

        cpu_ctrl = 2'b01;
        cpu_addr = 8'h0B;
        #1;
        chk("run_rd_ctrl", 32'(mem_ctrl_a), 32'd1);
        chk("run_rd_addr", 32'(mem_addr_a), 32'h0B);
        chk("run_rd_data", 32'(cpu_rd_a),   32'hA1);
        chk("run_hold",    32'(hold_a),     32'd0);
        chk("run_rom",     32'(rom_addr_a), 32'd3);
        cpu_ctrl = 2'b11;
        cpu_addr = 8'h20;
        cpu_wr   = 8'h77;
        #1;
        chk("run_ill_ctrl", 32'(mem_ctrl_a), 32'd3);
        chk("run_ill_addr", 32'(mem_addr_a), 32'h20);
        chk("run_ill_data", 32'(mem_wr_a),   32'h77);

        chk("a_mem0A", 32'(mem_a[8'h0A]), 32'hA0);
        chk("a_mem0D", 32'(mem_a[8'h0D]), 32'hA3);
        chk("b_memFE", 32'(mem_b[8'hFE]), 32'hA0);
        chk("b_memFF", 32'(mem_b[8'hFF]), 32'hA1);
        chk("b_mem00", 32'(mem_b[8'h00]), 32'hA2);
        chk("b_mem01", 32'(mem_b[8'h01]), 32'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
